// File: rtl/butterfly_scheduler.sv
// rtl/butterfly_scheduler.sv - in-place radix-2 butterfly scheduler over two parity-interleaved banks
module butterfly_scheduler #(
    parameter int LOG_N        = 13,
    parameter int ADDR_WIDTH   = 12,
    parameter int DRAIN_CYCLES = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_fft_in,
    input  logic                  is_dif_in,
    input  logic                  stall,
    output logic                  is_fft,
    output logic                  is_dif,
    output logic [ADDR_WIDTH-1:0] read_addr_0,
    output logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic                  read_swap,
    output logic                  dest_bank_a,
    output logic                  dest_bank_b,
    output logic                  valid_a,
    output logic                  valid_b,
    output logic [ADDR_WIDTH-1:0] dest_addr_a,
    output logic [ADDR_WIDTH-1:0] dest_addr_b,
    output logic [LOG_N-2:0]      tw_idx,
    output logic                  busy,
    output logic                  done
);
    localparam int KW = LOG_N - 1;
    localparam int SW = $clog2(LOG_N + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [KW-1:0]    K_LAST = '1;
    localparam logic [SW-1:0]    S_LAST = SW'(LOG_N - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            fft_q, fft_d;
    logic            dif_q, dif_d;
    logic            issue;

    logic            valid_q;
    logic            bank_a_q;
    logic [KW-1:0]   addr_a_q, addr_b_q, tw_q;

    logic [SW-1:0]    s, tw_sh;
    logic [LOG_N-1:0] mask, k_ext, ia;
    logic [KW-1:0]    ia_addr, ib_addr, tw;
    logic             par_a;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        fft_d   = fft_q;
        dif_d   = dif_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                    stage_d = '0;
                    drain_d = '0;
                    fft_d   = is_fft_in;
                    dif_d   = is_dif_in;
                end
            end
            RUN: begin
                if (!stall) begin
                    issue = 1'b1;
                    k_d   = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // stall is deliberately not looked at here: drain length is fixed
                if (drain_q == D_LAST) begin
                    drain_d = '0;
                    if (stage_q == S_LAST) begin
                        state_d = FINISH;
                        stage_d = '0;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ia is k with a zero spliced in at bit s; ib differs only in bit s
    always_comb begin
        s       = dif_q ? (S_LAST - stage_q) : stage_q;
        tw_sh   = S_LAST - s;
        mask    = (ONE << s) - ONE;
        k_ext   = {1'b0, k_q};
        ia      = ((k_ext & ~mask) << 1) | (k_ext & mask);
        par_a   = ^ia;
        ia_addr = ia[LOG_N-1:1];
        ib_addr = (s == '0) ? ia_addr : (ia_addr | (KW'(1) << (s - SW'(1))));
        tw      = (k_q & mask[KW-1:0]) << tw_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            stage_q  <= '0;
            drain_q  <= '0;
            fft_q    <= 1'b0;
            dif_q    <= 1'b0;
            valid_q  <= 1'b0;
            bank_a_q <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
            fft_q   <= fft_d;
            dif_q   <= dif_d;
            valid_q <= issue;
            if (issue) begin
                bank_a_q <= par_a;
                addr_a_q <= ia_addr;
                addr_b_q <= ib_addr;
                tw_q     <= tw;
            end
        end
    end

    // ia and ib always differ in exactly one bit, so they sit in opposite banks
    assign dest_bank_a = bank_a_q;
    assign dest_bank_b = valid_q ? ~bank_a_q : 1'b0;
    assign read_swap   = bank_a_q;
    assign read_addr_0 = bank_a_q ? addr_b_q : addr_a_q;
    assign read_addr_1 = bank_a_q ? addr_a_q : addr_b_q;
    assign dest_addr_a = addr_a_q;
    assign dest_addr_b = addr_b_q;
    assign tw_idx      = tw_q;
    assign valid_a     = valid_q;
    assign valid_b     = valid_q;
    assign is_fft      = fft_q;
    assign is_dif      = dif_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FINISH);
endmodule

// File: tb/tb_butterfly_scheduler.sv
// tb/tb_butterfly_scheduler.sv - scoreboard bench for butterfly_scheduler (LOG_N=3 and LOG_N=4 instances)
`timescale 1ns/1ps
module tb_butterfly_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic       start3, fft_in3, dif_in3, stall3;
    logic       fft3, dif3, swap3, dba3, dbb3, va3, vb3, busy3, done3;
    logic [1:0] ra0_3, ra1_3, daa3, dab3, tw3;
    logic       or3;

    logic       start4, fft_in4, dif_in4, stall4;
    logic       fft4, dif4, swap4, dba4, dbb4, va4, vb4, busy4, done4;
    logic [2:0] ra0_4, ra1_4, daa4, dab4, tw4;
    logic       or4;

    butterfly_scheduler #(.LOG_N(3), .ADDR_WIDTH(2), .DRAIN_CYCLES(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .is_fft_in(fft_in3), .is_dif_in(dif_in3),
        .stall(stall3), .is_fft(fft3), .is_dif(dif3), .read_addr_0(ra0_3), .read_addr_1(ra1_3),
        .read_swap(swap3), .dest_bank_a(dba3), .dest_bank_b(dbb3), .valid_a(va3), .valid_b(vb3),
        .dest_addr_a(daa3), .dest_addr_b(dab3), .tw_idx(tw3), .busy(busy3), .done(done3)
    );

    butterfly_scheduler #(.LOG_N(4), .ADDR_WIDTH(3), .DRAIN_CYCLES(3)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .is_fft_in(fft_in4), .is_dif_in(dif_in4),
        .stall(stall4), .is_fft(fft4), .is_dif(dif4), .read_addr_0(ra0_4), .read_addr_1(ra1_4),
        .read_swap(swap4), .dest_bank_a(dba4), .dest_bank_b(dbb4), .valid_a(va4), .valid_b(vb4),
        .dest_addr_a(daa4), .dest_addr_b(dab4), .tw_idx(tw4), .busy(busy4), .done(done4)
    );

    assign or3 = |{fft3, dif3, ra0_3, ra1_3, swap3, dba3, dbb3, va3, vb3, daa3, dab3, tw3, busy3, done3};
    assign or4 = |{fft4, dif4, ra0_4, ra1_4, swap4, dba4, dbb4, va4, vb4, daa4, dab4, tw4, busy4, done4};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int par(input int v);
        return int'(^v);
    endfunction

    function automatic int pk(input int ba, input int bb, input int sw, input int aa,
                              input int ab, input int r0, input int r1, input int tw);
        return (ba << 22) | (bb << 21) | (sw << 20) | (aa << 16) | (ab << 12) | (r0 << 8) | (r1 << 4) | tw;
    endfunction

    function automatic int expk(input int ia, input int ib, input int tw);
        int b  = par(ia);
        int aa = ia >> 1;
        int ab = ib >> 1;
        return pk(b, 1 - b, b, aa, ab, (b != 0) ? ab : aa, (b != 0) ? aa : ab, tw);
    endfunction

    int q3[$];
    int q4[$];

    // LOG_N=3 pairs per span, blocks ordered s=2, s=1, s=0
    int t_ia [12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
    int t_ib [12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
    int t_tw [12] = '{0, 1, 2, 3,  0, 2, 0, 2,  0, 0, 0, 0};

    task automatic push3(input logic dif);
        for (int st = 0; st < 3; st++) begin
            int blk = dif ? st : 2 - st;
            for (int j = 0; j < 4; j++)
                q3.push_back(expk(t_ia[blk*4+j], t_ib[blk*4+j], t_tw[blk*4+j]));
        end
    endtask

    task automatic push4(input logic dif);
        for (int st = 0; st < 4; st++) begin
            int s   = dif ? 3 - st : st;
            int cnt = 0;
            for (int i = 0; i < 16; i++) begin
                if (((i >> s) & 1) == 0) begin
                    q4.push_back(expk(i, i | (1 << s), (cnt % (1 << s)) << (3 - s)));
                    cnt++;
                end
            end
        end
    endtask

    int done_seen3 = 0;
    always @(negedge clk) begin
        if (done3) done_seen3++;
        if (va3 || vb3) begin
            check("valid_pair3", int'({va3, vb3}), 3);
            if (q3.size() == 0) check("sb3_underflow", 1, 0);
            else check("sb3", pk(int'(dba3), int'(dbb3), int'(swap3), int'(daa3), int'(dab3),
                                 int'(ra0_3), int'(ra1_3), int'(tw3)), q3.pop_front());
        end
    end

    int wr4 [16] = '{default: 0};
    int issued4 = 0;
    always @(negedge clk) begin
        if (va4 || vb4) begin
            int ia;
            int ib;
            int bad;
            check("bank_ne4", int'(dba4 != dbb4), 1);
            if (q4.size() == 0) check("sb4_underflow", 1, 0);
            else check("sb4", pk(int'(dba4), int'(dbb4), int'(swap4), int'(daa4), int'(dab4),
                                 int'(ra0_4), int'(ra1_4), int'(tw4)), q4.pop_front());
            // rebuild the coefficient index from bank and address alone
            ia = (int'(daa4) << 1) | int'(dba4 ^ (^daa4));
            ib = (int'(dab4) << 1) | int'(dbb4 ^ (^dab4));
            wr4[ia]++;
            wr4[ib]++;
            issued4++;
            if (issued4 % 8 == 0) begin
                bad = 0;
                for (int i = 0; i < 16; i++) begin
                    if (wr4[i] != 1) bad++;
                    wr4[i] = 0;
                end
                check("once_per_stage4", bad, 0);
            end
        end
    end

    task automatic start_dut(input int which, input logic dif, input logic fft, output int t0);
        @(posedge clk); #1;
        if (which == 3) begin
            start3 = 1'b1; dif_in3 = dif; fft_in3 = fft;
        end else begin
            start4 = 1'b1; dif_in4 = dif; fft_in4 = fft;
        end
        t0 = cyc;
        @(posedge clk); #1;
        start3 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int t0, input int exp_lat, input string name);
        int seen = 0;
        int lat  = -1;
        for (int i = 0; i < 300 && seen == 0; i++) begin
            @(negedge clk);
            if ((which == 3) ? done3 : done4) begin
                seen = 1;
                lat  = cyc - t0;
            end
        end
        check({name, "_latency"}, lat, exp_lat);
        @(negedge clk);
        check({name, "_one_pulse"}, int'((which == 3) ? done3 : done4), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int t0;
        int ds;
        rst = 1'b1;
        start3 = 1'b0; fft_in3 = 1'b0; dif_in3 = 1'b0; stall3 = 1'b0;
        start4 = 1'b0; fft_in4 = 1'b0; dif_in4 = 1'b0; stall4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_zero3", int'(or3), 0);
        check("reset_zero4", int'(or4), 0);
        rst = 1'b0;

        // DIF run: spans 4,2,1
        push3(1'b1);
        start_dut(3, 1'b1, 1'b0, t0);
        check("dif_latched", int'(dif3), 1);
        check("busy_run", int'(busy3), 1);
        wait_done(3, t0, 19, "dif_run");
        check("q3_empty_dif", q3.size(), 0);

        // DIT run with fft mode: spans 1,2,4
        push3(1'b0);
        start_dut(3, 1'b0, 1'b1, t0);
        check("fft_latched", int'(fft3), 1);
        check("dit_latched", int'(dif3), 0);
        wait_done(3, t0, 19, "dit_run");
        check("q3_empty_dit", q3.size(), 0);

        // three-cycle stall in the first stage
        push3(1'b1);
        start_dut(3, 1'b1, 1'b0, t0);
        repeat (2) @(posedge clk);
        #1;
        stall3 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid_low", int'(va3 | vb3), 0);
        end
        stall3 = 1'b0;
        wait_done(3, t0, 22, "stall_run");
        check("q3_empty_stall", q3.size(), 0);

        // abort during the second stage's drain
        push3(1'b1);
        start_dut(3, 1'b1, 1'b0, t0);
        repeat (11) @(posedge clk);
        #1;
        check("pairs_before_abort", q3.size(), 4);
        ds = done_seen3;
        rst = 1'b1;
        #1;
        check("abort_zero", int'(or3), 0);
        q3.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_done", done_seen3, ds);
        check("abort_idle", int'(busy3), 0);
        push3(1'b1);
        start_dut(3, 1'b1, 1'b0, t0);
        wait_done(3, t0, 19, "post_abort_run");
        check("q3_empty_post_abort", q3.size(), 0);

        // LOG_N=4 with a start (and mode change) while busy
        push4(1'b1);
        start_dut(4, 1'b1, 1'b0, t0);
        repeat (4) @(posedge clk);
        #1;
        start4 = 1'b1; dif_in4 = 1'b0; fft_in4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        check("busy_start_dif_held", int'(dif4), 1);
        check("busy_start_fft_held", int'(fft4), 0);
        wait_done(4, t0, 45, "n16_run");
        check("q4_empty", q4.size(), 0);
        check("n16_issued", issued4, 32);
        repeat (5) @(posedge clk);
        #1;
        check("n16_idle_after", int'(busy4), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
